// File: rtl/apb_wr_master.sv
// APB write master: pops {id, addr, data} entries from the bridge FIFO,
// runs each as an APB write (SETUP then ACCESS) and returns ID + RESP on
// a valid/ready channel. A programmable ACCESS timeout aborts hung transfers.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no transfer in flight, ready to pop the next FIFO entry
// S_SETUP | APB SETUP phase (PSEL=1, PENABLE=0), exactly one cycle
// S_ACCESS| APB ACCESS phase, waits for PREADY or the timeout
// S_RESP  | response offered; a new entry may be popped on acceptance
module apb_wr_master #(
  parameter int ID_NUM      = 4,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                            ACLK_i,
  input  logic                            ARESETn_i,
  input  logic                            fifo_rvld_i,
  output logic                            fifo_rrdy_o,
  input  logic [ID_NUM+ADDR_W+DATA_W-1:0] fifo_rpayload_i,
  output logic [ADDR_W-1:0]               PADDR_o,
  output logic                            PSEL_o,
  output logic                            PENABLE_o,
  output logic                            PWRITE_o,
  output logic [DATA_W-1:0]               PWDATA_o,
  input  logic                            PREADY_i,
  input  logic                            PSLVERR_i,
  output logic                            rsp_vld_o,
  input  logic                            rsp_rdy_i,
  output logic [ID_NUM-1:0]               rsp_id_o,
  output logic [1:0]                      rsp_resp_o,
  output logic                            timeout_o
);

  localparam int PAY_W = ID_NUM + ADDR_W + DATA_W;
  // A zero TIMEOUT_CYC disables the abort; keep the counter at least 1 bit wide.
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e              state_q;
  logic [ID_NUM-1:0]   id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [1:0]          resp_q;
  logic                psel_q;
  logic                penable_q;
  logic                rsp_vld_q;
  logic                timeout_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                pop;

  // Pop request is the only input-to-output path; held low while in reset.
  assign fifo_rrdy_o = ARESETn_i & ((state_q == S_IDLE) | ((state_q == S_RESP) & rsp_rdy_i));
  assign pop         = fifo_rvld_i & fifo_rrdy_o;

  assign PADDR_o    = addr_q;
  assign PWDATA_o   = data_q;
  assign PSEL_o     = psel_q;
  assign PENABLE_o  = penable_q;
  assign PWRITE_o   = psel_q;
  assign rsp_vld_o  = rsp_vld_q;
  assign rsp_id_o   = id_q;
  assign rsp_resp_o = resp_q;
  assign timeout_o  = timeout_q;

  // Transfer sequencer with registered APB and response outputs.
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      resp_q    <= RESP_OKAY;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rsp_vld_q <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      if (pop) begin
        id_q   <= fifo_rpayload_i[PAY_W-1 -: ID_NUM];
        addr_q <= fifo_rpayload_i[DATA_W +: ADDR_W];
        data_q <= fifo_rpayload_i[DATA_W-1:0];
      end
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q <= S_SETUP;
            psel_q  <= 1'b1;
          end
        end
        S_SETUP: begin
          state_q   <= S_ACCESS;
          penable_q <= 1'b1;
        end
        S_ACCESS: begin
          if (PREADY_i) begin
            resp_q    <= PSLVERR_i ? RESP_SLVERR : RESP_OKAY;
            cnt_q     <= '0;
            state_q   <= S_RESP;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rsp_vld_q <= 1'b1;
          end else if (TO_EN && (cnt_q == CNT_LAST)) begin
            resp_q    <= RESP_SLVERR;
            timeout_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= S_RESP;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rsp_vld_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_rdy_i) begin
            rsp_vld_q <= 1'b0;
            // Back-to-back: the next entry was popped this same cycle.
            if (fifo_rvld_i) begin
              state_q <= S_SETUP;
              psel_q  <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_wr_master.md
# apb_wr_master

Downstream stage of the AXI slave interface in the AXI-to-APB bridge. It pops write entries `{id, addr, data}` from the bridge FIFO and executes each one as an APB write transfer (SETUP then ACCESS). It returns a per-transfer response (ID + RESP) on a valid/ready channel for B-channel generation. A programmable ACCESS-phase timeout stops a hung peripheral from stalling the bridge.

## Interface
- ID_NUM, 4, transaction ID width
- ADDR_W, 12, APB address width
- DATA_W, 32, APB data width
- TIMEOUT_CYC, 256, maximum ACCESS cycles with PREADY low before the transfer is aborted; 0 disables the timeout

- ACLK_i  in  1  clock
- ARESETn_i  in  1  reset; asynchronous assert, active-low
- fifo_rvld_i  in  1  FIFO entry available
- fifo_rrdy_o  out  1  pop request; an entry is popped on fifo_rvld_i & fifo_rrdy_o
- fifo_rpayload_i  in  ID_NUM+ADDR_W+DATA_W  packed {id[MSBs], addr, data[LSBs]}
- PADDR_o  out  ADDR_W  APB address
- PSEL_o  out  1  APB select
- PENABLE_o  out  1  APB enable
- PWRITE_o  out  1  APB direction; this block only writes
- PWDATA_o  out  DATA_W  APB write data
- PREADY_i  in  1  completer ready
- PSLVERR_i  in  1  completer error
- rsp_vld_o  out  1  response valid
- rsp_rdy_i  in  1  response accepted
- rsp_id_o  out  ID_NUM  ID of the completed transfer
- rsp_resp_o  out  2  2'b00 = OKAY, 2'b10 = SLVERR
- timeout_o  out  1  one-cycle pulse when a transfer is aborted by timeout

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. The state is registered. Reset state is IDLE.
- IDLE
  - fifo_rrdy_o = 1.
  - On a pop, latch id/addr/data into the holding registers and go to SETUP.
- SETUP
  - PSEL_o = 1, PENABLE_o = 0.
  - Stays exactly one cycle, then goes to ACCESS.
- ACCESS
  - PSEL_o = 1, PENABLE_o = 1.
  - If PREADY_i = 1: rsp_resp_o <= PSLVERR_i ? 2'b10 : 2'b00, clear the timeout counter, go to RESP.
  - If PREADY_i = 0: increment the timeout counter.
  - If TIMEOUT_CYC != 0, the counter reaches TIMEOUT_CYC-1, and PREADY_i = 0: set rsp_resp_o <= 2'b10, pulse timeout_o for the next cycle, go to RESP. PSEL_o and PENABLE_o drop in that next cycle.
  - Timeout counter width is $clog2(TIMEOUT_CYC+1).
- RESP
  - rsp_vld_o = 1. rsp_id_o and rsp_resp_o are held stable until the handshake.
  - On rsp_rdy_i = 1: if fifo_rvld_i = 1, pop in the same cycle and go to SETUP; otherwise go to IDLE.
  - fifo_rrdy_o = rsp_rdy_i.
- fifo_rrdy_o = (state==IDLE) | (state==RESP & rsp_rdy_i). This is the only combinational path from input to output.
- PADDR_o and PWDATA_o come from the holding registers. They stay stable from SETUP through the last ACCESS cycle. They update only on a pop.
- PSEL_o and PENABLE_o decode from the registered state and never glitch on inputs.
- Reset mid-transfer:
  - All outputs go to 0 immediately (asynchronous). The FSM returns to IDLE and the timeout counter clears.
  - The in-flight transfer is dropped and no response is issued.
- Entries are processed strictly in FIFO order. No reordering and no outstanding transfers beyond one.

## Timing
- Reset values: fifo_rrdy_o = 1 (IDLE) once ARESETn_i is high; 0 while reset is asserted. All other outputs are 0 during reset: PADDR_o, PSEL_o, PENABLE_o, PWRITE_o, PWDATA_o, rsp_vld_o, rsp_id_o, rsp_resp_o, timeout_o.
- Pop at edge N:
  - SETUP during cycle N+1.
  - ACCESS from N+2.
  - With zero wait states, rsp_vld_o = 1 at N+3.
- Each wait state (PREADY_i low in ACCESS) adds one cycle.
- Sustained throughput with rsp_rdy_i = 1 and the FIFO non-empty: one transfer per 3 cycles (SETUP, ACCESS, RESP).
- Response backpressure: while rsp_rdy_i = 0 in RESP, no new pop occurs and PSEL_o stays 0.
- The timeout abort happens on the TIMEOUT_CYC-th consecutive ACCESS cycle with PREADY_i low.
- PREADY_i and PSLVERR_i are sampled only in ACCESS. They are ignored in all other states.

## Test plan
- Single write, zero wait: payload {4'h3, 12'h010, 32'hDEADBEEF}, PREADY_i = 1. Required response:
  - PSEL_o rises 1 cycle after the pop and PENABLE_o 1 cycle later.
  - PADDR_o = 12'h010, PWDATA_o = 32'hDEADBEEF.
  - rsp_id_o = 3, rsp_resp_o = 00, rsp_vld_o 3 cycles after the pop.
- Wait states: PREADY_i low for 3 ACCESS cycles, then high. Required response: ACCESS lasts 4 cycles, PADDR_o/PWDATA_o are stable throughout, and the response arrives 3 cycles later than in the zero-wait case.
- Error: PREADY_i = 1 with PSLVERR_i = 1 on id 4'hA. Required response: rsp_id_o = A, rsp_resp_o = 2'b10, timeout_o stays 0.
- Timeout: TIMEOUT_CYC = 16, PREADY_i held 0. Required response:
  - PSEL_o/PENABLE_o drop after 16 ACCESS cycles.
  - timeout_o pulses for 1 cycle.
  - rsp_resp_o = 2'b10.
  - The next entry then proceeds normally.
- Back-to-back with backpressure: 3 entries queued (ids 1, 2, 3), rsp_rdy_i = 1, PREADY_i = 1. Required response: one transfer every 3 cycles, responses in order 1, 2, 3. Then hold rsp_rdy_i = 0 for 5 cycles: fifo_rrdy_o = 0 and no PSEL_o during the stall.
- Reset mid-ACCESS: assert ARESETn_i low while PENABLE_o = 1. Required response:
  - All outputs go to 0 at once.
  - No response is issued for the dropped entry.
  - After release, fifo_rrdy_o = 1 and the next entry completes normally.
